// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding decode.
//
// Generates the program counter and issues one 32-bit instruction fetch at a
// time over a doubleword-indexed memory channel. Returned instructions are
// queued with their PCs in a small FIFO for decode. A backend redirect
// flushes the queue, discards any in-flight response and restarts fetching at
// the redirect target.
//
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   redirect_valid/_target backend redirect pulse and new PC (bits [1:0] ignored)
//   fetch_index_valid/     fetch request (doubleword index = pc[21:3]) and the
//   fetch_index/_ready     memory's acceptance
//   fetch_read_data,       returned doubleword and its one-cycle valid pulse
//   fetch_operation_done
//   ibuf_valid/_instr/_pc  head of the instruction queue for decode
//   ibuf_ready             decode consumes the head entry
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        fetch_index_valid,
    output logic [18:0] fetch_index,
    input  logic        fetch_index_ready,
    input  logic [63:0] fetch_read_data,
    input  logic        fetch_operation_done,
    output logic        ibuf_valid,
    output logic [31:0] ibuf_instr,
    output logic [63:0] ibuf_pc,
    input  logic        ibuf_ready
);

    localparam int unsigned      PTR_W    = $clog2(QDEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [63:0]      fetch_pc, fetch_pc_next;
    logic [18:0]      req_index;
    logic             drop, drop_next;
    logic [CNT_W-1:0] count, count_next;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;

    logic [31:0]      instr_q [QDEPTH];
    logic [63:0]      pc_q    [QDEPTH];

    logic             resp;
    logic             enq;
    logic             deq;
    logic [31:0]      resp_instr;
    logic [63:0]      redirect_pc;
    logic             unused_target_bits;

    assign redirect_pc        = {redirect_target[63:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];

    // A response only counts while waiting for one; a late done after reset
    // lands in IDLE and is ignored.
    assign resp = (state == WAIT) && fetch_operation_done;

    // A response coinciding with a redirect belongs to the old stream.
    assign enq = resp && !drop && !redirect_valid;

    // Masking valid during a redirect keeps decode from consuming an entry
    // that is being flushed in the same cycle.
    assign ibuf_valid = (count != '0) && !redirect_valid;
    assign deq        = ibuf_valid && ibuf_ready;

    assign resp_instr = fetch_pc[2] ? fetch_read_data[63:32] : fetch_read_data[31:0];

    assign fetch_index_valid = (state == REQ);
    // The request index is latched on entry to REQ so a redirect that moves
    // fetch_pc cannot change an address the memory has not yet accepted.
    assign fetch_index       = req_index;

    assign ibuf_instr = instr_q[rd_ptr];
    assign ibuf_pc    = pc_q[rd_ptr];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_next    = count;
        fetch_pc_next = fetch_pc;
        drop_next     = drop;
        state_next    = state;

        if (redirect_valid) begin
            count_next = '0;
        end else begin
            count_next = count + CNT_W'(enq) - CNT_W'(deq);
        end

        // A dropped response does not advance the PC: fetch_pc already holds
        // the redirect target.
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
        end else if (resp && !drop) begin
            fetch_pc_next = fetch_pc + 64'd4;
        end

        // Any request issued or pending when a redirect arrives produces a
        // response that must be discarded; the response itself clears drop.
        if (resp) begin
            drop_next = 1'b0;
        end else if (redirect_valid && (state == REQ || state == WAIT)) begin
            drop_next = 1'b1;
        end

        case (state)
            IDLE: begin
                if (count_next < FULL_CNT) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (fetch_index_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (fetch_operation_done) begin
                    state_next = (count_next < FULL_CNT) ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            req_index <= '0;
            drop      <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            drop     <= drop_next;
            count    <= count_next;

            if (state_next == REQ && state != REQ) begin
                req_index <= fetch_pc_next[21:3];
            end

            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // NOTE: the queue storage is reset because the head entry drives
    // ibuf_instr/ibuf_pc directly and those must read zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (enq) begin
            instr_q[wr_ptr] <= resp_instr;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit sitting directly upstream of decode and the backend. Generates the program counter, issues one 32-bit instruction fetch at a time over a 19-bit-index / 64-bit-data memory channel, and buffers returned instructions with their PCs in a small FIFO for decode. It consumes the backend's `redirect_valid`/`redirect_target`, flushing buffered and in-flight fetches and restarting at the target.

## Interface
- `RESET_PC`, 64'h0000_0000_8000_0000, PC fetched first after reset.
- `QDEPTH`, 4, instruction queue entries; power of two, ≥2.
- `clock`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  backend redirect pulse.
- `redirect_target`  in  64  new PC; bits [1:0] ignored (treated as 0).
- `fetch_index_valid`  out  1  fetch request valid.
- `fetch_index`  out  19  64-bit word index, equal to pc[21:3].
- `fetch_index_ready`  in  1  memory accepts request.
- `fetch_read_data`  in  64  returned doubleword.
- `fetch_operation_done`  in  1  data valid pulse; never in the same cycle as the accepting `ready`.
- `ibuf_valid`  out  1  head entry valid for decode.
- `ibuf_instr`  out  32  head instruction.
- `ibuf_pc`  out  64  head PC.
- `ibuf_ready`  in  1  decode consumes head; decode holds it low while the backend stalls.

## Operation
- State machine: IDLE, REQ, WAIT. At most one fetch is in flight.
- IDLE -> REQ when the next-cycle queue count < QDEPTH.
- REQ: `fetch_index_valid`=1. `fetch_index` is held stable from `fetch_pc`.
  - A request is never withdrawn before `fetch_index_ready`.
  - REQ -> WAIT on ready.
- WAIT -> on `fetch_operation_done`:
  - Unless `drop` is set, enqueue {instr, `fetch_pc`}.
  - Instruction select: `fetch_pc`[2] ? data[63:32] : data[31:0].
  - Advance `fetch_pc` by 4, with 64-bit wrap.
  - Go to REQ if the next-cycle count < QDEPTH, else IDLE.
- Dequeue occurs when `ibuf_valid & ibuf_ready`.
  - Enqueue and dequeue may happen in the same cycle; the count is unchanged.
  - Enqueue into a full queue cannot occur: a fetch starts only when a slot is free, and only one fetch is in flight.
- Redirect, any state:
  - Queue pointers and count clear to 0.
  - `fetch_pc` <= {target[63:2], 2'b0}.
  - If state is WAIT, or REQ in any cycle (request handed off or not), set `drop`. The pending response is discarded and `drop` clears on its done.
    - A REQ not yet accepted stays asserted with its old index until ready, then proceeds as a dropped request.
  - After the dropped response completes, fetching starts from the target.
  - If IDLE, go to REQ next cycle with the target.
- Redirect in the same cycle as done: the data is discarded, and the next request uses the target.
- Redirect in the same cycle as a dequeue handshake: `ibuf_valid` is forced 0 that cycle, so no instruction is consumed.
- `ibuf_valid` = ~empty & ~`redirect_valid`. `ibuf_instr`/`ibuf_pc` come from the head entry (registered storage).

## Timing
- Reset values:
  - state IDLE, `fetch_pc`=RESET_PC, count 0, `drop` 0.
  - `fetch_index_valid`=0, `ibuf_valid`=0.
  - `ibuf_instr`=0, `ibuf_pc`=0 (storage cleared).
- First cycle after reset release: IDLE -> REQ. `fetch_index_valid`=1 from the second cycle, with `fetch_index`=RESET_PC[21:3].
- Fetch-to-decode latency: `ibuf_valid` rises the cycle after `fetch_operation_done`.
- Back-to-back fetches: the new REQ asserts the cycle after done, giving a throughput of one instruction per (memory latency + 2) cycles.
- Redirect effects:
  - Queue is empty from the cycle after the redirect.
  - If idle or no fetch is in flight, the new request is visible 1 cycle later.
- Reset asserted mid-fetch: everything returns to reset values immediately. A late done after reset is ignored because state is IDLE.

## Test plan
- Reset release, memory readies next cycle, done 2 cycles later, data 64'h00B5_0533_0010_0093:
  - `fetch_index`=19'h0 (for 0x8000_0000).
  - `ibuf` shows instr 32'h0010_0093, pc 0x8000_0000.
  - Next fetch pc 0x8000_0004 yields instr 32'h00B5_0533.
- `ibuf_ready`=0 permanently: exactly 4 entries fill, PCs 0x8000_0000..0x8000_000C. `fetch_index_valid` stays 0 afterward. Raising ready drains them in order.
- Redirect to 0x8000_1002 while in WAIT:
  - Returned data is discarded.
  - Next request index is 0x8000_1000[21:3].
  - First `ibuf_pc`=0x8000_1000.
- Redirect in the same cycle as done and as a dequeue handshake: no entry consumed, data dropped, queue empty next cycle, next fetch from target.
- Hold `fetch_index_ready`=0 for 5 cycles while redirect pulses: index stays stable. After ready and done the response is dropped, then a fetch of the target follows.
- Assert reset_n low during WAIT, then a done arrives during reset: all outputs are 0. After release, fetch restarts at RESET_PC.
